// File: rtl/decim_pkg.sv
// Shared constants and state encoding for the decimating capture controller.
//   DefDataWidth  - default sample width
//   DefRatioWidth - default width of the decimation factor
//   DefLenWidth   - default width of settle/length/count fields
//   state_e       - capture FSM states
package decim_pkg;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefRatioWidth = 8;
  localparam int unsigned DefLenWidth   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StDone
  } state_e;

endpackage

// File: rtl/decim_tick_gen.sv
// Decimation counter and tick generation.
//   clk, rstn - clock, asynchronous active-low reset
//   clear     - restart the count (first valid sample afterwards ticks)
//   en        - allow ticks to be issued
//   ratio     - decimation factor; 0 and 1 both mean every sample
//   vld       - input sample valid
//   tick      - current sample is selected
module decim_tick_gen
  import decim_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = DefRatioWidth
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   en,
  input  logic [RATIO_WIDTH-1:0] ratio,
  input  logic                   vld,
  output logic                   tick
);

  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic                   wrap;

  // Ratios 0 and 1 keep the counter pinned at 0 so every valid sample ticks.
  assign wrap = (ratio <= RATIO_WIDTH'(1)) || (cnt_q == ratio - RATIO_WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (vld) begin
      cnt_d = wrap ? '0 : cnt_q + RATIO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & vld & (cnt_q == '0);

endmodule

// File: rtl/decim_capture_ctrl.sv
// Decimating capture controller: after start, discards cfg_settle decimated
// samples, then captures cfg_len decimated samples into a single-entry output
// register with a valid/ready handshake.
//   clk, rstn                  - clock, asynchronous active-low reset
//   cfg_ratio/settle/len       - configuration, latched on accepted start
//   start, abort               - single-cycle capture request / cancel
//   data_in, data_in_vld       - input sample stream
//   data_out, data_out_vld/rdy - captured sample and handshake
//   busy                       - high while settling or capturing
//   done                       - one-cycle completion pulse
//   overflow                   - sticky: a selected sample was dropped
//   sample_cnt                 - samples handshaken in current/last capture
module decim_capture_ctrl
  import decim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned RATIO_WIDTH = DefRatioWidth,
  parameter int unsigned LEN_WIDTH   = DefLenWidth
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic [LEN_WIDTH-1:0]   cfg_settle,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_vld,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_vld,
  input  logic                   data_out_rdy,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [LEN_WIDTH-1:0]   sample_cnt
);

  state_e                 state_q, state_d;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [LEN_WIDTH-1:0]   settle_q, len_q;
  logic [LEN_WIDTH-1:0]   settle_cnt_q, settle_cnt_d;
  logic [LEN_WIDTH-1:0]   load_cnt_q, load_cnt_d;
  logic [LEN_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   out_vld_q, out_vld_d;
  logic                   overflow_q, overflow_d;

  logic start_acc, abort_acc, handshake, tick_en, tick;

  // Abort wins over a simultaneous start.
  assign start_acc = start & ~abort & (state_q == StIdle);
  assign abort_acc = abort & (state_q != StIdle);
  assign handshake = out_vld_q & data_out_rdy;
  // Ticking stops once len samples have been loaded.
  assign tick_en   = (state_q == StSettle) ||
                     ((state_q == StCapture) && (load_cnt_q != len_q));

  decim_tick_gen #(
    .RATIO_WIDTH(RATIO_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clear(start_acc),
    .en   (tick_en),
    .ratio(ratio_q),
    .vld  (data_in_vld),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    load_cnt_d   = load_cnt_q;
    sample_cnt_d = sample_cnt_q;
    data_out_d   = data_out_q;
    out_vld_d    = out_vld_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          settle_cnt_d = '0;
          load_cnt_d   = '0;
          sample_cnt_d = '0;
          overflow_d   = 1'b0;
          if (cfg_settle != '0)   state_d = StSettle;
          else if (cfg_len != '0) state_d = StCapture;
          else                    state_d = StDone;
        end
      end
      StSettle: begin
        if (tick) begin
          settle_cnt_d = settle_cnt_q + LEN_WIDTH'(1);
          if (settle_cnt_q == settle_q - LEN_WIDTH'(1)) begin
            state_d = (len_q != '0) ? StCapture : StDone;
          end
        end
      end
      StCapture: begin
        if (handshake) begin
          out_vld_d    = 1'b0;
          sample_cnt_d = sample_cnt_q + LEN_WIDTH'(1);
          if (sample_cnt_q + LEN_WIDTH'(1) == len_q) state_d = StDone;
        end
        if (tick) begin
          // A slot frees up either when empty or when drained this cycle.
          if (!out_vld_q || handshake) begin
            data_out_d = data_in;
            out_vld_d  = 1'b1;
            load_cnt_d = load_cnt_q + LEN_WIDTH'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_acc) begin
      state_d   = StIdle;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      ratio_q      <= '0;
      settle_q     <= '0;
      len_q        <= '0;
      settle_cnt_q <= '0;
      load_cnt_q   <= '0;
      sample_cnt_q <= '0;
      data_out_q   <= '0;
      out_vld_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      load_cnt_q   <= load_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      data_out_q   <= data_out_d;
      out_vld_q    <= out_vld_d;
      overflow_q   <= overflow_d;
      if (start_acc) begin
        ratio_q  <= cfg_ratio;
        settle_q <= cfg_settle;
        len_q    <= cfg_len;
      end
    end
  end

  assign data_out     = data_out_q;
  assign data_out_vld = out_vld_q;
  assign busy         = (state_q == StSettle) || (state_q == StCapture);
  assign done         = (state_q == StDone);
  assign overflow     = overflow_q;
  assign sample_cnt   = sample_cnt_q;

endmodule

// File: doc/decim_capture_ctrl.md
DECIM_CAPTURE_CTRL -- requirements
Module: decim_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample width.
REQ-002 SHALL have parameter RATIO_WIDTH, default 8, width of the decimation factor.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the settle, length and count fields.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rstn  in  1  reset; asynchronous, active-low
- cfg_ratio  in  RATIO_WIDTH  decimation factor; 0 and 1 both mean keep every sample
- cfg_settle  in  LEN_WIDTH  decimated samples to discard after start
- cfg_len  in  LEN_WIDTH  decimated samples to capture
- start  in  1  single-cycle capture request
- abort  in  1  single-cycle cancel
- data_in  in  DATA_WIDTH  input sample
- data_in_vld  in  1  input sample valid
- data_out  out  DATA_WIDTH  captured sample
- data_out_vld  out  1  captured sample valid
- data_out_rdy  in  1  downstream accepts data_out
- busy  out  1  high in SETTLE or CAPTURE
- done  out  1  single-cycle completion pulse
- overflow  out  1  sticky dropped-sample flag
- sample_cnt  out  LEN_WIDTH  samples handshaken in the current or last capture

Function
REQ-005 SHALL latch cfg_ratio, cfg_settle and cfg_len on the cycle start is accepted; later changes SHALL have no effect until the next start.
REQ-006 SHALL implement states IDLE, SETTLE, CAPTURE and DONE.
REQ-007 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-008 SHALL transition from IDLE on an accepted start as follows:
- to SETTLE when settle≠0;
- else to CAPTURE when len≠0;
- else to DONE.
REQ-009 SHALL keep a decimation counter that is cleared at start, increments only on data_in_vld, and wraps to 0 after ratio-1.
REQ-010 SHALL select a sample (tick) when data_in_vld=1 and the counter=0, so the first valid sample after start is selected.
REQ-011 SHALL, in SETTLE, discard each ticked sample, count it, and move to CAPTURE after the settle-th tick (to DONE if len=0).
REQ-012 SHALL, in CAPTURE, load each ticked sample into a single-entry output register, asserting data_out_vld on the next cycle (latency 1).
REQ-013 SHALL hold data_out and data_out_vld stable until a cycle in which data_out_vld & data_out_rdy are both high.
REQ-014 SHALL, when a tick occurs while the register holds an unaccepted sample, drop the new sample, set overflow, and keep the held sample.
REQ-015 SHALL, when a tick coincides with a handshake, accept the new sample; this is not an overflow.
REQ-016 SHALL increment sample_cnt on every output handshake.
REQ-017 SHALL stop ticking once len samples have been loaded.
REQ-018 SHALL enter DONE on the handshake that brings sample_cnt to len.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL, on abort in any non-IDLE state, return to IDLE next cycle, clear data_out_vld, and suppress done; abort SHALL win over a simultaneous start.
REQ-021 SHALL clear overflow and sample_cnt only on an accepted start or on reset.
REQ-022 SHALL hold busy=1 exactly in SETTLE and CAPTURE.

Reset
REQ-023 SHALL, on rstn low, asynchronously force:
- state to IDLE;
- all counters, data_out, data_out_vld, done, busy, overflow and sample_cnt to 0.
REQ-024 SHALL abandon any capture in progress on reset with no done pulse.
REQ-025 SHALL release from reset synchronously to clk.

Structure
REQ-026 SHALL take the state encoding and the default DATA_WIDTH, RATIO_WIDTH and LEN_WIDTH constants from a shared package, decim_pkg.
REQ-027 SHALL implement the ratio counter and tick generation in one sub-module, decim_tick_gen.

Verification
REQ-028 SHALL verify: ratio=10, settle=0, len=3, continuous vld, rdy=1 -> input samples 0, 10 and 20 appear one cycle late, done pulses once, sample_cnt=3.
REQ-029 SHALL verify: ratio=4, settle=2, len=2 -> samples 0 and 4 are discarded, samples 8 and 12 are output.
REQ-030 SHALL verify: ratio=1, len=4, rdy=0 for 3 cycles -> first sample held, overflow=1, 3 further samples dropped.
REQ-031 SHALL verify: len=0, settle=0 -> done on the second cycle after start, no data_out_vld.
REQ-032 SHALL verify: abort mid-CAPTURE with data_out_vld=1 -> IDLE next cycle, data_out_vld=0, no done; a new start behaves normally.
REQ-033 SHALL verify: rstn asserted mid-SETTLE with clk stopped -> outputs 0 immediately.
